// File: rtl/hs_spi_arb_pkg.sv
// hs_spi_avmm_arb shared types: arbiter FSM state encoding and the
// filler word returned to a requester whose read response timed out.
package hs_spi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam logic [31:0] HS_SPI_ARB_TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/avmm_if.sv
// Single-clock Avalon-MM bundle with slave-side (s) and master-side (m)
// modports; burstcount is sized for MAX_BURST beats.
interface avmm_if #(
    parameter int AW        = 10,
    parameter int DW        = 32,
    parameter int MAX_BURST = 1
);
    localparam int BW = $clog2(MAX_BURST) + 1;

    logic [AW-1:0]   address;
    logic            read;
    logic            write;
    logic [DW/8-1:0] byteenable;
    logic [DW-1:0]   writedata;
    logic [BW-1:0]   burstcount;
    logic [DW-1:0]   readdata;
    logic            readdatavalid;
    logic            waitrequest;

    modport s (
        input  address, read, write, byteenable, writedata, burstcount,
        output readdata, readdatavalid, waitrequest
    );

    modport m (
        output address, read, write, byteenable, writedata, burstcount,
        input  readdata, readdatavalid, waitrequest
    );

endinterface

// File: rtl/hs_spi_arb_timer.sv
// Read-response watchdog: clr zeroes the count, en advances it, expired
// is high while the count equals TIMEOUT-1. Ports: clk, rst, clr, en, expired.
module hs_spi_arb_timer #(
    parameter int TIMEOUT = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/hs_spi_avmm_arb.sv
// Round-robin two-port Avalon-MM arbiter in front of one HS-SPI master.
// Ports: clk, rst (async high), s0/s1 requesters (avmm_if.s), m to the
// SPI master (avmm_if.m), busy, owner (last grant), err_timeout (sticky).
// Optional read timeout enabled by defining HS_SPI_ARB_TIMEOUT_EN.
module hs_spi_avmm_arb
    import hs_spi_arb_pkg::*;
#(
    parameter int AW      = 10,
    parameter int DW      = 32,
    parameter int TIMEOUT = 4096
) (
    input  logic clk,
    input  logic rst,
    avmm_if.s    s0,
    avmm_if.s    s1,
    avmm_if.m    m,
    output logic busy,
    output logic owner,
    output logic err_timeout
);

    arb_state_t    state_q;
    arb_state_t    state_d;
    logic          owner_d;
    logic          p0;
    logic          p1;
    logic          own_rd;
    logic          own_wr;
    logic          in_cmd;
    logic          in_resp;
    logic          tmo;
    logic          rsp_vld;
    logic [DW-1:0] rdata;

    assign p0      = s0.read | s0.write;
    assign p1      = s1.read | s1.write;
    assign in_cmd  = (state_q == CMD);
    assign in_resp = (state_q == RESP);
    assign own_rd  = owner ? s1.read  : s0.read;
    assign own_wr  = owner ? s1.write : s0.write;

`ifdef HS_SPI_ARB_TIMEOUT_EN
    logic expired;
    logic tmr_clr;
    logic unused_cfg;

    assign tmr_clr = (state_d == RESP) & ~in_resp;

    hs_spi_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .en      (in_resp),
        .expired (expired)
    );

    // Real data arriving on the expiry cycle takes precedence.
    assign tmo = in_resp & expired & ~m.readdatavalid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_timeout <= 1'b0;
        end else if (tmo) begin
            err_timeout <= 1'b1;
        end
    end

    assign unused_cfg = ^{AW};
`else
    logic unused_cfg;

    assign tmo         = 1'b0;
    assign err_timeout = 1'b0;
    assign unused_cfg  = ^{AW, TIMEOUT};
`endif

    assign rsp_vld = in_resp & (m.readdatavalid | tmo);
    assign rdata   = tmo ? DW'(HS_SPI_ARB_TIMEOUT_DATA) : m.readdata;

    always_comb begin
        state_d = state_q;
        owner_d = owner;
        unique case (state_q)
            IDLE: begin
                if (p0 | p1) begin
                    state_d = CMD;
                    // On contention the port that did not go last wins.
                    owner_d = (p0 & p1) ? ~owner : p1;
                end
            end
            CMD: begin
                if (!(own_rd | own_wr)) begin
                    state_d = IDLE;
                end else if (!m.waitrequest) begin
                    state_d = own_rd ? RESP : IDLE;
                end
            end
            RESP: begin
                if (m.readdatavalid | tmo) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner   <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner   <= owner_d;
            busy    <= (state_d != IDLE);
        end
    end

    assign m.address    = owner ? s1.address    : s0.address;
    assign m.byteenable = owner ? s1.byteenable : s0.byteenable;
    assign m.writedata  = owner ? s1.writedata  : s0.writedata;
    assign m.burstcount = owner ? s1.burstcount : s0.burstcount;
    assign m.read       = in_cmd & own_rd;
    assign m.write      = in_cmd & own_wr;

    assign s0.waitrequest   = ~(in_cmd & ~owner) | m.waitrequest;
    assign s1.waitrequest   = ~(in_cmd &  owner) | m.waitrequest;
    assign s0.readdatavalid = rsp_vld & ~owner;
    assign s1.readdatavalid = rsp_vld &  owner;
    assign s0.readdata      = rdata;
    assign s1.readdata      = rdata;

endmodule

// File: tb/tb_hs_spi_avmm_arb.sv
// Directed bench for hs_spi_avmm_arb with an m-side scoreboard of
// expected grants and per-read expected data.
module tb_hs_spi_avmm_arb;

    typedef struct packed {
        logic        p;
        logic        wr;
        logic [9:0]  a;
        logic [31:0] d;
    } txn_t;

    logic clk;
    logic rst;
    logic busy;
    logic owner;
    logic err_timeout;

    int n_vec = 0;
    int n_err = 0;

    txn_t        sbq[$];
    logic [31:0] sl_data[$];
    txn_t        mon_e;

    avmm_if #(.AW(10), .DW(32), .MAX_BURST(1)) s0_if ();
    avmm_if #(.AW(10), .DW(32), .MAX_BURST(1)) s1_if ();
    avmm_if #(.AW(10), .DW(32), .MAX_BURST(1)) m_if ();

    hs_spi_avmm_arb #(
        .AW      (10),
        .DW      (32),
        .TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s0          (s0_if),
        .s1          (s1_if),
        .m           (m_if),
        .busy        (busy),
        .owner       (owner),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic p, input logic wr, input logic [9:0] a,
                        input logic [31:0] d);
        txn_t t;
        t.p  = p;
        t.wr = wr;
        t.a  = a;
        t.d  = d;
        sbq.push_back(t);
    endtask

    task automatic drive(input logic p, input logic rd, input logic wr,
                         input logic [9:0] a, input logic [31:0] d);
        if (p) begin
            s1_if.read       = rd;
            s1_if.write      = wr;
            s1_if.address    = a;
            s1_if.writedata  = d;
            s1_if.byteenable = 4'hF;
            s1_if.burstcount = 1'b1;
        end else begin
            s0_if.read       = rd;
            s0_if.write      = wr;
            s0_if.address    = a;
            s0_if.writedata  = d;
            s0_if.byteenable = 4'hF;
            s0_if.burstcount = 1'b1;
        end
    endtask

    function automatic logic wreq(input logic p);
        return p ? s1_if.waitrequest : s0_if.waitrequest;
    endfunction

    function automatic logic rdv(input logic p);
        return p ? s1_if.readdatavalid : s0_if.readdatavalid;
    endfunction

    function automatic logic [31:0] rdat(input logic p);
        return p ? s1_if.readdata : s0_if.readdata;
    endfunction

    // One requester transaction: hold until accepted, then for reads
    // wait for the routed response and compare against rexp.
    task automatic req(input logic p, input logic wr, input logic [9:0] a,
                       input logic [31:0] d, input logic [31:0] rexp);
        int  n;
        logic ok;
        drive(p, ~wr, wr, a, d);
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 200) begin
            @(negedge clk);
            if (wreq(p) == 1'b0) ok = 1'b1;
            n++;
        end
        check("accept", ok, 1'b1);
        @(posedge clk);
        #1;
        drive(p, 1'b0, 1'b0, 10'h0, 32'h0);
        if (!wr) begin
            n  = 0;
            ok = 1'b0;
            while (!ok && n < 200) begin
                @(negedge clk);
                if (rdv(p)) ok = 1'b1;
                n++;
            end
            check("rdv_seen", ok, 1'b1);
            if (ok) begin
                check("rdata", rdat(p), rexp);
                check("rdv_other", rdv(~p), 1'b0);
            end
        end
    endtask

    task automatic serve_reads(input int cnt, input int lat);
        int  n;
        logic ok;
        for (int k = 0; k < cnt; k++) begin
            n  = 0;
            ok = 1'b0;
            while (!ok && n < 200) begin
                @(negedge clk);
                if (m_if.read && !m_if.waitrequest) ok = 1'b1;
                n++;
            end
            check("slave_acc", ok, 1'b1);
            @(posedge clk);
            #1;
            repeat (lat) tick();
            m_if.readdatavalid = 1'b1;
            m_if.readdata      = (sl_data.size() > 0) ? sl_data.pop_front()
                                                      : 32'h0;
            tick();
            m_if.readdatavalid = 1'b0;
        end
    endtask

    task automatic port_writes(input logic p);
        for (int k = 0; k < 8; k++) begin
            req(p, 1'b1, (p ? 10'h100 : 10'h080) + 10'(k),
                (p ? 32'hB000_0000 : 32'hA000_0000) + 32'(k), 32'h0);
        end
    endtask

    // Every accepted m-side beat must match the next expected grant.
    always @(negedge clk) begin
        if (!rst && (m_if.read || m_if.write) && !m_if.waitrequest) begin
            check("sb_nonempty", 32'(sbq.size() > 0), 32'h1);
            if (sbq.size() > 0) begin
                mon_e = sbq.pop_front();
                check("grant", owner, mon_e.p);
                check("kind", m_if.write, mon_e.wr);
                check("addr", m_if.address, mon_e.a);
                if (mon_e.wr) check("wdata", m_if.writedata, mon_e.d);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n;
        rst                = 1'b1;
        m_if.waitrequest   = 1'b0;
        m_if.readdatavalid = 1'b0;
        m_if.readdata      = 32'h0;
        drive(1'b0, 1'b0, 1'b0, 10'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 10'h0, 32'h0);
        repeat (2) tick();

        check("rst_busy", busy, 1'b0);
        check("rst_owner", owner, 1'b1);
        check("rst_err", err_timeout, 1'b0);
        check("rst_mread", m_if.read, 1'b0);
        check("rst_mwrite", m_if.write, 1'b0);
        check("rst_s0_wr", s0_if.waitrequest, 1'b1);
        check("rst_s1_wr", s1_if.waitrequest, 1'b1);
        check("rst_s0_rdv", s0_if.readdatavalid, 1'b0);
        check("rst_s1_rdv", s1_if.readdatavalid, 1'b0);
        rst = 1'b0;
        tick();

        // contention: s0 wins first after reset
        push(1'b0, 1'b0, 10'h020, 32'h0);
        push(1'b1, 1'b0, 10'h024, 32'h0);
        sl_data.push_back(32'hA5A5_A5A5);
        sl_data.push_back(32'h5A5A_5A5A);
        fork
            req(1'b0, 1'b0, 10'h020, 32'h0, 32'hA5A5_A5A5);
            req(1'b1, 1'b0, 10'h024, 32'h0, 32'h5A5A_5A5A);
            serve_reads(2, 1);
        join
        tick();

        // sustained write contention alternates 0,1,0,1
        for (int k = 0; k < 8; k++) begin
            push(1'b0, 1'b1, 10'h080 + 10'(k), 32'hA000_0000 + 32'(k));
            push(1'b1, 1'b1, 10'h100 + 10'(k), 32'hB000_0000 + 32'(k));
        end
        fork
            port_writes(1'b0);
            port_writes(1'b1);
        join
        tick();
        check("sust_drain", sbq.size(), 0);

        // solo write with two slave wait cycles
        push(1'b0, 1'b1, 10'h010, 32'h1234_5678);
        m_if.waitrequest = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 10'h010, 32'h1234_5678);
        tick();
        check("sw_mwrite", m_if.write, 1'b1);
        check("sw_addr", m_if.address, 10'h010);
        check("sw_wdata", m_if.writedata, 32'h1234_5678);
        check("sw_be", m_if.byteenable, 4'hF);
        check("sw_burst", m_if.burstcount, 1'b1);
        check("sw_busy", busy, 1'b1);
        check("sw_s0_wr1", s0_if.waitrequest, 1'b1);
        tick();
        check("sw_s0_wr2", s0_if.waitrequest, 1'b1);
        check("sw_s1_wr2", s1_if.waitrequest, 1'b1);
        m_if.waitrequest = 1'b0;
        #1;
        check("sw_s0_acc", s0_if.waitrequest, 1'b0);
        check("sw_s1_acc", s1_if.waitrequest, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 10'h0, 32'h0);
        #1;
        check("sw_done_busy", busy, 1'b0);
        check("sw_done_mw", m_if.write, 1'b0);
        check("sw_done_wr", s0_if.waitrequest, 1'b1);
        tick();

        // reset while in RESP; late response is dropped
        push(1'b0, 1'b0, 10'h030, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 10'h030, 32'h0);
        tick();
        tick();
        drive(1'b0, 1'b0, 1'b0, 10'h0, 32'h0);
        check("rr_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("rr_busy_rst", busy, 1'b0);
        repeat (3) tick();
        rst = 1'b0;
        m_if.readdatavalid = 1'b1;
        m_if.readdata      = 32'h1111_2222;
        #1;
        check("rr_s0_rdv", s0_if.readdatavalid, 1'b0);
        check("rr_s1_rdv", s1_if.readdatavalid, 1'b0);
        tick();
        m_if.readdatavalid = 1'b0;
        check("rr_busy_after", busy, 1'b0);
        check("rr_owner", owner, 1'b1);

        // stray response in IDLE
        tick();
        m_if.readdatavalid = 1'b1;
        m_if.readdata      = 32'h3333_4444;
        #1;
        check("st_s0_rdv", s0_if.readdatavalid, 1'b0);
        check("st_s1_rdv", s1_if.readdatavalid, 1'b0);
        tick();
        m_if.readdatavalid = 1'b0;
        check("st_busy", busy, 1'b0);
        check("st_mread", m_if.read, 1'b0);

`ifdef HS_SPI_ARB_TIMEOUT_EN
        // s1 read never answered: filler after 16 RESP cycles
        push(1'b1, 1'b0, 10'h040, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 10'h040, 32'h0);
        tick();
        @(negedge clk);
        check("to_acc", s1_if.waitrequest, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 10'h0, 32'h0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!s1_if.readdatavalid && n < 100);
        check("to_cycles", n, 16);
        check("to_rdata", s1_if.readdata, 32'hDEAD_BEEF);
        check("to_s0_rdv", s0_if.readdatavalid, 1'b0);
        tick();
        check("to_err", err_timeout, 1'b1);
        check("to_busy", busy, 1'b0);
        push(1'b0, 1'b1, 10'h050, 32'hCAFE_F00D);
        req(1'b0, 1'b1, 10'h050, 32'hCAFE_F00D, 32'h0);
        tick();
        check("to_err_sticky", err_timeout, 1'b1);
`else
        n = 0;
        check("err_tied", err_timeout, 1'b0);
`endif

        tick();
        check("sb_empty", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hs_spi_avmm_arb.md
# hs_spi_avmm_arb

Two-port Avalon-MM arbiter that shares one `hs_spi_master_avmm_m` instance between two requesters, e.g. the CPU path from `axi2avmm` and an autonomous register poller. It sits between the requesters and the HS-SPI master on the same clock. It grants one single-beat transaction at a time, round-robin, and holds the grant until that transaction completes on the SPI side.

## Interface
Parameters:
- `AW`, 10, address width of all three AVMM ports
- `DW`, 32, data width of all three AVMM ports
- `TIMEOUT`, 4096, read-response timeout in `clk` cycles; used only with `HS_SPI_ARB_TIMEOUT_EN`

Ports:
- `clk` in 1: single clock for all ports.
- `rst` in 1: asynchronous, active-high reset.
- `s0` in `avmm_if.s`, `MAX_BURST(1)`: requester 0, with address, write, read, byteenable, writedata, readdata, readdatavalid, burstcount and waitrequest.
- `s1` in `avmm_if.s`, `MAX_BURST(1)`: requester 1, same signals as `s0`.
- `m` out `avmm_if.m`, `MAX_BURST(1)`: to the HS-SPI master.
- `busy` out 1: high while a transaction is owned.
- `owner` out 1: index of the current or last granted requester.
- `err_timeout` out 1: sticky read-timeout flag, cleared only by `rst`.

## Operation
- FSM states are `IDLE`, `CMD` and `RESP`.
- **`IDLE` arbitration:**
  - A requester is pending when its `read|write` is high.
  - One pending requester: it is granted.
  - Both pending: the requester that is not `owner` is granted.
  - Grant registers `owner` and moves to `CMD`.
- **`CMD`:**
  - `m.address`, `m.read`, `m.write`, `m.byteenable`, `m.writedata` and `m.burstcount` equal the owner's signals (combinational mux).
  - The owner's `waitrequest` equals `m.waitrequest`.
- **Write accepted** (`m.write & ~m.waitrequest`): go to `IDLE`.
- **Read accepted** (`m.read & ~m.waitrequest`): go to `RESP`.
- **Owner drops `read|write` in `CMD`** (protocol violation): go to `IDLE`. Nothing is forwarded afterwards.
- **`RESP`:**
  - `m.read` and `m.write` are 0.
  - On `m.readdatavalid`, the owner sees `readdatavalid=1` and `readdata=m.readdata` in that cycle, and the FSM goes to `IDLE`.
- **Requester-side signals at all times:**
  - A non-owner, or any port outside `CMD`, sees `waitrequest=1`.
  - `readdatavalid` is asserted only to the owner, only in `RESP`.
  - `readdata` is driven to both ports from `m.readdata`.
- **Stray `m.readdatavalid`** in `IDLE` or `CMD`: dropped, not routed to either port.
- `burstcount` is forwarded unchanged and is always 1.
- Fairness: under continuous contention, grants alternate 0,1,0,1.

## Timing
- **Reset values:**
  - State `IDLE`; `owner=1`, so `s0` wins the first contention.
  - `busy=0`, `err_timeout=0`.
  - `m.read=0`, `m.write=0`.
  - `s0.waitrequest=1`, `s1.waitrequest=1`.
  - `readdatavalid=0` on both ports.
- **Arbitration latency:** a request seen at edge N is presented on `m` from cycle N+1.
- **Turnaround:** one `IDLE` cycle between consecutive transactions, so throughput is at most one transaction per 2 cycles plus slave latency.
- **Read latency added by the arbiter:** 1 cycle on the command path, 0 on the response path.
- **Simultaneous completion and new request:** the completion cycle returns to `IDLE`, and the new request is arbitrated on the next edge.
- **`rst` mid-transaction:** the transaction is aborted and the FSM goes to `IDLE` immediately. A late `m.readdatavalid` is dropped.
- `busy` is registered: high in `CMD` and `RESP`.

## Configuration
- Macro: `HS_SPI_ARB_TIMEOUT_EN`.
- **Defined:**
  - A counter clears on entry to `RESP` and increments each `RESP` cycle.
  - When it reaches `TIMEOUT-1` with no `m.readdatavalid`, the owner gets `readdatavalid=1` and `readdata=HS_SPI_ARB_TIMEOUT_DATA` (32'hDEAD_BEEF).
  - `err_timeout` sets and the FSM goes to `IDLE`.
  - If `m.readdatavalid` arrives in the same cycle as expiry, the real data wins and no error is flagged.
- **Undefined:**
  - `RESP` waits indefinitely.
  - `err_timeout` is tied to 0 and `TIMEOUT` is ignored.

## Structure
- Package `hs_spi_arb_pkg`:
  - state enum `arb_state_t` (`IDLE`, `CMD`, `RESP`)
  - constant `HS_SPI_ARB_TIMEOUT_DATA`
- Sub-module `hs_spi_arb_timer`: `clk`, `rst`, `clr`, `en`, output `expired`, parameter `TIMEOUT`. It is instantiated only under the macro.

## Test plan
- **Solo write:** `s0` writes addr 0x010, data 0x12345678, slave waitrequest 2 cycles → one `m.write` beat with identical fields; `s0.waitrequest` low exactly on the accept cycle; `s1.waitrequest` stays 1.
- **Contention after reset:** `s0` and `s1` both read at once → `s0` served first, then `s1`; `readdatavalid` reaches only the matching port with slave data 0xA5A5A5A5 and 0x5A5A5A5A respectively.
- **Sustained contention:** both ports issue 8 back-to-back writes → the grant order on `m` alternates 0,1,0,1…; no transaction is lost or duplicated.
- **Reset during `RESP`:** assert `rst` while in `RESP`, then inject `m.readdatavalid` 3 cycles later → the FSM is `IDLE`, neither port sees `readdatavalid`, and `busy=0`.
- **Timeout (`HS_SPI_ARB_TIMEOUT_EN`, `TIMEOUT=16`):** slave never answers a `s1` read → after 16 cycles `s1` gets 0xDEADBEEF, `err_timeout=1`, and a following `s0` write completes normally.
- **Stray response:** slave pulses `readdatavalid` while in `IDLE` → not routed to either port, and the FSM stays in `IDLE`.
